// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath responder: ALU operation codes,
// default datapath width and the hard-wired zero register index.
package datapath_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [4:0] {
    ALU_OR   = 5'd1,
    ALU_AND  = 5'd2,
    ALU_XOR  = 5'd3,
    ALU_SLL  = 5'd4,
    ALU_SRL  = 5'd5,
    ALU_SRA  = 5'd6,
    ALU_SLT  = 5'd7,
    ALU_SLTU = 5'd8,
    ALU_EQ   = 5'd9,
    ALU_ADD  = 5'd12,
    ALU_SUB  = 5'd13
  } alu_op_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath responder; unlisted opcodes yield 0.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_EQ:   result = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_responder.sv
// Register file, operand latches and shared result bus driven by control-path strobes.
// Optional sticky bus-conflict detection is built when DATAPATH_BUS_CONFLICT_EN is defined.
module datapath_responder
  import datapath_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      alu_function_sel,
  input  logic            alu_store_1,
  input  logic            alu_store_2,
  input  logic            alu_broadcast,
  input  logic [4:0]      register_index,
  input  logic            register_read_enable,
  input  logic            register_write_enable,
  input  logic [XLEN-1:0] imm,
  input  logic            imm_EN,
  input  logic [4:0]      dbg_index,
  output logic [XLEN-1:0] bus_value,
  output logic [XLEN-1:0] dbg_data,
  output logic            zero_flag,
  output logic            bus_conflict
);

  logic [XLEN-1:0] regs [REG_COUNT];
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] rf_rd;

  datapath_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op_t'(alu_function_sel)),
    .result (alu_result)
  );

  assign rf_rd    = (register_index == REG_ZERO) ? '0 : regs[register_index];
  assign dbg_data = (dbg_index == REG_ZERO) ? '0 : regs[dbg_index];

  always_comb begin
    bus_value = '0;
    if (alu_broadcast)             bus_value = alu_result;
    else if (imm_EN)               bus_value = imm;
    else if (register_read_enable) bus_value = rf_rd;
  end

  // Same-index read+write writes back the value just read, so the entry is unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      op_a      <= '0;
      op_b      <= '0;
      zero_flag <= 1'b0;
    end else begin
      if (register_write_enable && (register_index != REG_ZERO))
        regs[register_index] <= bus_value;
      if (alu_store_1) op_a <= bus_value;
      if (alu_store_2) op_b <= bus_value;
      if (alu_broadcast) zero_flag <= (alu_result == '0);
    end
  end

`ifdef DATAPATH_BUS_CONFLICT_EN
  logic multi_src;
  logic conflict_q;

  assign multi_src = (alu_broadcast & imm_EN) | (alu_broadcast & register_read_enable) |
                     (imm_EN & register_read_enable);

  always_ff @(posedge clk) begin
    if (reset)          conflict_q <= 1'b0;
    else if (multi_src) conflict_q <= 1'b1;
  end

  assign bus_conflict = conflict_q;
`else
  assign bus_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_responder.sv
// Directed self-checking bench for datapath_responder.
module tb_datapath_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  alu_function_sel;
  logic        alu_store_1;
  logic        alu_store_2;
  logic        alu_broadcast;
  logic [4:0]  register_index;
  logic        register_read_enable;
  logic        register_write_enable;
  logic [31:0] imm;
  logic        imm_EN;
  logic [4:0]  dbg_index;
  logic [31:0] bus_value;
  logic [31:0] dbg_data;
  logic        zero_flag;
  logic        bus_conflict;

  int checks = 0;
  int errors = 0;

`ifdef DATAPATH_BUS_CONFLICT_EN
  localparam logic EXP_CONFLICT = 1'b1;
`else
  localparam logic EXP_CONFLICT = 1'b0;
`endif

  datapath_responder dut (
    .clk                   (clk),
    .reset                 (reset),
    .alu_function_sel      (alu_function_sel),
    .alu_store_1           (alu_store_1),
    .alu_store_2           (alu_store_2),
    .alu_broadcast         (alu_broadcast),
    .register_index        (register_index),
    .register_read_enable  (register_read_enable),
    .register_write_enable (register_write_enable),
    .imm                   (imm),
    .imm_EN                (imm_EN),
    .dbg_index             (dbg_index),
    .bus_value             (bus_value),
    .dbg_data              (dbg_data),
    .zero_flag             (zero_flag),
    .bus_conflict          (bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_function_sel      = 5'd0;
    alu_store_1           = 1'b0;
    alu_store_2           = 1'b0;
    alu_broadcast         = 1'b0;
    register_index        = 5'd0;
    register_read_enable  = 1'b0;
    register_write_enable = 1'b0;
    imm                   = 32'd0;
    imm_EN                = 1'b0;
  endtask

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    idle();
    imm = a; imm_EN = 1'b1; alu_store_1 = 1'b1;
    step();
    idle();
    imm = b; imm_EN = 1'b1; alu_store_2 = 1'b1;
    step();
    idle();
  endtask

  task automatic alu_peek(input string tag, input logic [4:0] sel, input logic [31:0] exp);
    idle();
    alu_function_sel = sel;
    alu_broadcast    = 1'b1;
    #1;
    chk(tag, bus_value, exp);
  endtask

  initial begin
    idle();
    dbg_index = 5'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;

    for (int i = 0; i < 32; i++) begin
      dbg_index = 5'(i);
      #1;
      chk($sformatf("reset_x%0d", i), dbg_data, 32'd0);
    end
    chk("reset_bus", bus_value, 32'd0);
    chk("reset_zf", {31'd0, zero_flag}, 32'd0);
    chk("reset_conf", {31'd0, bus_conflict}, 32'd0);

    // addi x5, x0, 7
    idle(); register_index = 5'd0; register_read_enable = 1'b1; alu_store_1 = 1'b1;
    step();
    idle(); imm = 32'd7; imm_EN = 1'b1; alu_store_2 = 1'b1;
    step();
    idle(); alu_function_sel = 5'd12; alu_broadcast = 1'b1;
    register_index = 5'd5; register_write_enable = 1'b1;
    #1;
    chk("addi_bus", bus_value, 32'd7);
    step();
    idle(); dbg_index = 5'd5; #1;
    chk("addi_x5", dbg_data, 32'd7);
    chk("addi_zf", {31'd0, zero_flag}, 32'd0);

    // pre-load x6 with a nonzero value so the sub result is observable
    idle(); imm = 32'h55; imm_EN = 1'b1; register_index = 5'd6; register_write_enable = 1'b1;
    step();
    // sub x6, x5, x5
    idle(); register_index = 5'd5; register_read_enable = 1'b1;
    alu_store_1 = 1'b1; alu_store_2 = 1'b1;
    #1;
    chk("sub_read_x5", bus_value, 32'd7);
    step();
    idle(); alu_function_sel = 5'd13; alu_broadcast = 1'b1;
    register_index = 5'd6; register_write_enable = 1'b1;
    step();
    idle(); dbg_index = 5'd6; #1;
    chk("sub_x6", dbg_data, 32'd0);
    chk("sub_zf", {31'd0, zero_flag}, 32'd1);
    step();
    chk("zf_hold", {31'd0, zero_flag}, 32'd1);

    // SRA
    load_ab(32'h8000_0000, 32'd4);
    alu_peek("sra", 5'd6, 32'hF800_0000);
    register_index = 5'd7; register_write_enable = 1'b1;
    step();
    idle(); dbg_index = 5'd7; #1;
    chk("sra_x7", dbg_data, 32'hF800_0000);
    chk("sra_zf", {31'd0, zero_flag}, 32'd0);

    // A = -1, B = 1 across the opcode space
    load_ab(32'hFFFF_FFFF, 32'd1);
    alu_peek("slt",  5'd7,  32'd1);
    alu_peek("sltu", 5'd8,  32'd0);
    alu_peek("or",   5'd1,  32'hFFFF_FFFF);
    alu_peek("and",  5'd2,  32'd1);
    alu_peek("xor",  5'd3,  32'hFFFF_FFFE);
    alu_peek("sll",  5'd4,  32'hFFFF_FFFE);
    alu_peek("srl",  5'd5,  32'h7FFF_FFFF);
    alu_peek("eq",   5'd9,  32'd0);
    alu_peek("add",  5'd12, 32'd0);
    alu_peek("sub",  5'd13, 32'hFFFF_FFFE);
    alu_peek("op0",  5'd0,  32'd0);
    alu_peek("op10", 5'd10, 32'd0);
    alu_peek("op31", 5'd31, 32'd0);
    alu_peek("sltu_b", 5'd8, 32'd0);
    step();
    chk("sltu_zf", {31'd0, zero_flag}, 32'd1);

    // x0 protection
    idle(); imm = 32'hDEAD_BEEF; imm_EN = 1'b1; register_index = 5'd0; register_write_enable = 1'b1;
    step();
    idle(); dbg_index = 5'd0; #1;
    chk("x0_prot", dbg_data, 32'd0);

    // read and write same index leaves the entry unchanged
    idle(); register_index = 5'd5; register_read_enable = 1'b1; register_write_enable = 1'b1;
    step();
    idle(); dbg_index = 5'd5; #1;
    chk("rw_same_x5", dbg_data, 32'd7);

    // conflict and priority
    idle(); imm = 32'd3; imm_EN = 1'b1; register_index = 5'd5; register_read_enable = 1'b1;
    #1;
    chk("prio_imm_bus", bus_value, 32'd3);
    chk("conf_pre", {31'd0, bus_conflict}, 32'd0);
    step();
    idle(); #1;
    chk("conf_set", {31'd0, bus_conflict}, {31'd0, EXP_CONFLICT});
    step();
    step();
    chk("conf_sticky", {31'd0, bus_conflict}, {31'd0, EXP_CONFLICT});

    // broadcast beats imm (A = -1, B = 1, AND -> 1)
    idle(); alu_function_sel = 5'd2; alu_broadcast = 1'b1; imm = 32'h1234; imm_EN = 1'b1;
    #1;
    chk("prio_bcast_bus", bus_value, 32'd1);
    step();

    // reset wins over a same-cycle write
    idle(); reset = 1'b1;
    imm = 32'd9; imm_EN = 1'b1; register_index = 5'd8; register_write_enable = 1'b1;
    step();
    reset = 1'b0;
    idle(); dbg_index = 5'd8; #1;
    chk("reset_win_x8", dbg_data, 32'd0);
    dbg_index = 5'd5; #1;
    chk("reset_clr_x5", dbg_data, 32'd0);
    chk("reset_conf_clr", {31'd0, bus_conflict}, 32'd0);
    alu_peek("reset_ab_add", 5'd12, 32'd0);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
